// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: ALU ops, mult/div ops, result and forwarding selects.
// No logic of its own; zero latency.
// No flow control; encodings only.
package exec_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_LUI  = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;
  localparam logic [2:0] ALU_XOR  = 3'b111;

  localparam logic [2:0] MD_NONE  = 3'b000;
  localparam logic [2:0] MD_MULT  = 3'b001;
  localparam logic [2:0] MD_MULTU = 3'b010;
  localparam logic [2:0] MD_DIV   = 3'b011;
  localparam logic [2:0] MD_DIVU  = 3'b100;
  localparam logic [2:0] MD_MTHI  = 3'b101;
  localparam logic [2:0] MD_MTLO  = 3'b110;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_HI   = 2'b01;
  localparam logic [1:0] RES_LO   = 2'b10;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_W    = 2'b01;
  localparam logic [1:0] FWD_M    = 2'b10;

  typedef enum logic [1:0] {
    MDK_MULT,
    MDK_MULTU,
    MDK_DIV,
    MDK_DIVU
  } md_kind_e;

  function automatic logic is_mul_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/exec_stage_md_if.sv
// Execute-stage bundle: E-register operands, forwarding, control, and stage results.
// Combinational results; busy is registered.
// No handshake; the pipeline stalls on busy.
interface exec_stage_md_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] rd1_e;
  logic [WIDTH-1:0] rd2_e;
  logic [WIDTH-1:0] imm_e;
  logic [WIDTH-1:0] fwd_m;
  logic [WIDTH-1:0] fwd_w;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic             b_sel;
  logic [2:0]       alu_op;
  logic [2:0]       md_op;
  logic             md_start;
  logic [1:0]       res_sel;
  logic [WIDTH-1:0] result_e;
  logic [WIDTH-1:0] rd2_fwd;
  logic             busy;

  modport master (
    output rd1_e, rd2_e, imm_e, fwd_m, fwd_w, fwd_a_sel, fwd_b_sel,
           b_sel, alu_op, md_op, md_start, res_sel,
    input  result_e, rd2_fwd, busy
  );

  modport slave (
    input  rd1_e, rd2_e, imm_e, fwd_m, fwd_w, fwd_a_sel, fwd_b_sel,
           b_sel, alu_op, md_op, md_start, res_sel,
    output result_e, rd2_fwd, busy
  );
endinterface

// File: rtl/md_unit.sv
// HI/LO multiply-divide unit; divide support only when EXEC_STAGE_DIV_EN is defined.
// MULT_CYCLES / DIV_CYCLES busy cycles; HI/LO land on the edge that clears busy.
// Starts while busy are dropped; mthi/mtlo write in a single cycle.
module md_unit
  import exec_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  logic [CW-1:0]      cnt;
  md_kind_e           kind_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               is_div;
  logic               accept;
  logic               wr_en;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;

`ifdef EXEC_STAGE_DIV_EN
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  logic [WIDTH-1:0] quo_s;
  logic [WIDTH-1:0] rem_s;
  logic [WIDTH-1:0] quo_u;
  logic [WIDTH-1:0] rem_u;

  assign is_div = (op == MD_DIV) || (op == MD_DIVU);
  assign quo_s  = $signed(a_q) / $signed(b_q);
  assign rem_s  = $signed(a_q) % $signed(b_q);
  assign quo_u  = a_q / b_q;
  assign rem_u  = a_q % b_q;
`else
  assign is_div = 1'b0;
`endif

  assign accept = start && !busy;

  // Sign-extend to full product width so one unsigned multiply yields the signed product.
  assign prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
  assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

  always_comb begin
    wr_en  = 1'b1;
    res_hi = prod_s[2*WIDTH-1:WIDTH];
    res_lo = prod_s[WIDTH-1:0];
    case (kind_q)
      MDK_MULTU: {res_hi, res_lo} = prod_u;
`ifdef EXEC_STAGE_DIV_EN
      MDK_DIV: begin
        if (b_q == '0) begin
          wr_en = 1'b0;
        end else if ((a_q == MOST_NEG) && (b_q == '1)) begin
          res_hi = '0;
          res_lo = MOST_NEG;
        end else begin
          res_hi = rem_s;
          res_lo = quo_s;
        end
      end
      MDK_DIVU: begin
        if (b_q == '0) begin
          wr_en = 1'b0;
        end else begin
          res_hi = rem_u;
          res_lo = quo_u;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      cnt    <= '0;
      kind_q <= MDK_MULT;
      a_q    <= '0;
      b_q    <= '0;
    end else if (busy) begin
      if (cnt == '0) begin
        busy <= 1'b0;
        if (wr_en) begin
          hi <= res_hi;
          lo <= res_lo;
        end
      end else begin
        cnt <= cnt - 1'b1;
      end
    end else if (accept) begin
      if (is_mul_op(op) || is_div) begin
        busy <= 1'b1;
        a_q  <= a;
        b_q  <= b;
        cnt  <= is_div ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
        case (op)
          MD_MULTU: kind_q <= MDK_MULTU;
          MD_DIV:   kind_q <= MDK_DIV;
          MD_DIVU:  kind_q <= MDK_DIVU;
          default:  kind_q <= MDK_MULT;
        endcase
      end else if (op == MD_MTHI) begin
        hi <= a;
      end else if (op == MD_MTLO) begin
        lo <= a;
      end
    end
  end

endmodule

// File: rtl/exec_stage_md.sv
// Execute stage: operand forwarding, ALU, result select, HI/LO unit (divide under EXEC_STAGE_DIV_EN).
// ALU and forwarding are zero latency; HI/LO ops take MULT_CYCLES / DIV_CYCLES.
// busy tells the pipeline to stall; starts while busy are ignored.
module exec_stage_md
  import exec_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic         clk,
  input  logic         reset,
  exec_stage_md_if.slave io
);

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  always_comb begin
    case (io.fwd_a_sel)
      FWD_M:   op_a = io.fwd_m;
      FWD_W:   op_a = io.fwd_w;
      default: op_a = io.rd1_e;
    endcase
    case (io.fwd_b_sel)
      FWD_M:   op_b = io.fwd_m;
      FWD_W:   op_b = io.fwd_w;
      default: op_b = io.rd2_e;
    endcase
  end

  assign alu_b      = io.b_sel ? io.imm_e : op_b;
  assign io.rd2_fwd = op_b;

  always_comb begin
    alu_res = '0;
    case (io.alu_op)
      ALU_ADD:  alu_res = op_a + alu_b;
      ALU_SUB:  alu_res = op_a - alu_b;
      ALU_OR:   alu_res = op_a | alu_b;
      ALU_AND:  alu_res = op_a & alu_b;
      ALU_LUI:  alu_res = alu_b << (WIDTH / 2);
      ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(alu_b))};
      ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (op_a < alu_b)};
      ALU_XOR:  alu_res = op_a ^ alu_b;
      default:  alu_res = '0;
    endcase
  end

  // HI/LO come straight from the registers; a same-cycle mthi/mtlo is not bypassed.
  always_comb begin
    case (io.res_sel)
      RES_HI:  io.result_e = hi;
      RES_LO:  io.result_e = lo;
      default: io.result_e = alu_res;
    endcase
  end

  md_unit #(
    .WIDTH       (WIDTH),
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md (
    .clk   (clk),
    .reset (reset),
    .start (io.md_start),
    .op    (io.md_op),
    .a     (op_a),
    .b     (op_b),
    .hi    (hi),
    .lo    (lo),
    .busy  (io.busy)
  );

endmodule

// File: doc/exec_stage_md.md
EXEC_STAGE_MD -- requirements
Module: exec_stage_md

Interface
REQ-001 Parameter WIDTH, 32, datapath width in bits (even, >=8).
REQ-002 Parameter MULT_CYCLES, 5, busy cycles for MULT/MULTU (>=1).
REQ-003 Parameter DIV_CYCLES, 10, busy cycles for DIV/DIVU (>=1).
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 rd1_e / rd2_e  in  WIDTH  register-file operands from E pipeline register.
REQ-007 imm_e  in  WIDTH  extended immediate.
REQ-008 fwd_m / fwd_w  in  WIDTH  forwarded write-back data from M / W.
REQ-009 fwd_a_sel / fwd_b_sel  in  2  10=fwd_m, 01=fwd_w, others=rd1_e/rd2_e.
REQ-010 b_sel  in  1  ALU B: 0=forwarded rd2, 1=imm_e.
REQ-011 alu_op  in  3  000 add, 001 sub, 010 or, 011 and, 100 lui (B<<WIDTH/2), 101 slt, 110 sltu, 111 xor.
REQ-012 md_op  in  3  000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo.
REQ-013 md_start  in  1  qualifies md_op this cycle.
REQ-014 res_sel  in  2  00 ALU, 01 HI, 10 LO, 11 ALU.
REQ-015 result_e  out  WIDTH  selected result (combinational).
REQ-016 rd2_fwd  out  WIDTH  forwarded rd2, for store data.
REQ-017 busy  out  1  multiply/divide in progress (registered).

Function
REQ-018 ALU path and forwarding SHALL be combinational, zero latency.
REQ-019 slt SHALL compare signed, sltu unsigned; result 1 or 0 zero-extended.
REQ-020 add/sub SHALL wrap modulo 2^WIDTH, no overflow flag.
REQ-021 md_start with mult/multu/div/divu while busy=0 at edge t SHALL capture forwarded A and B, set busy from cycle t+1.
REQ-022 busy SHALL stay high exactly MULT_CYCLES (mult) or DIV_CYCLES (div) cycles; HI/LO update on the edge that clears busy.
REQ-023 mult/multu: {HI,LO} SHALL equal the 2*WIDTH-bit signed/unsigned product.
REQ-024 div/divu: LO=quotient truncated toward zero, HI=remainder with dividend sign.
REQ-025 Divisor zero: HI/LO SHALL remain unchanged; busy timing unchanged.
REQ-026 Signed most-negative / -1: LO=most-negative, HI=0.
REQ-027 mthi/mtlo with md_start while busy=0 SHALL write forwarded A into HI/LO at that edge, no busy.
REQ-028 md_start while busy=1 SHALL be ignored, in-flight operation unaffected.
REQ-029 res_sel HI/LO SHALL read the registered HI/LO (no bypass of same-cycle writes).
REQ-030 md_op none with md_start SHALL have no effect.

Reset
REQ-031 reset SHALL asynchronously clear HI, LO, busy and cycle counter to 0, including mid-operation (in-flight result discarded).
REQ-032 First md_start after reset release SHALL be accepted normally.

Configuration
REQ-033 Macro EXEC_STAGE_DIV_EN: defined = div/divu per REQ-024..026.
REQ-034 Undefined = div/divu treated as md_op none: no busy, HI/LO unchanged; no divider logic synthesised.

Structure
REQ-035 Package exec_pkg SHALL hold alu_op, md_op, res_sel and forwarding-select encodings as named constants.
REQ-036 Sub-module md_unit SHALL contain HI/LO, counter, busy and mult/div arithmetic; ALU and muxes stay in exec_stage_md.

Verification
REQ-037 fwd_a_sel=10, fwd_m=5, rd2_e=3, alu_op=sub, b_sel=0 -> result_e=2; fwd_a_sel=01 uses fwd_w.
REQ-038 mult A=0xFFFFFFFF, B=2 at t -> busy t+1..t+5, HI=0xFFFFFFFF, LO=0xFFFFFFFE at t+6; multu same -> HI=1.
REQ-039 div A=-7, B=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; B=0 -> HI/LO unchanged.
REQ-040 md_start mult while busy, or mtlo while busy -> ignored, original result lands on schedule.
REQ-041 reset asserted at busy cycle 3 -> busy, HI, LO =0 immediately; next mult completes correctly.
REQ-042 Build without EXEC_STAGE_DIV_EN: div start -> busy stays 0, HI/LO unchanged.
